nibble_stream_sequencer: RTL and testbench



---
 rtl/nibble_stream_sequencer.sv | 175 +++++++++++++++++
 tb/tb_nibble_stream_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_stream_sequencer.sv
// rtl/nibble_stream_sequencer.sv - byte FIFO feeding a two-beat nibble serializer
//
// Purpose: buffers bytes from a byte-wide valid/ready producer and emits each
//          one as two 4-bit beats on a valid/ready output, low or high nibble
//          first depending on HIGH_FIRST.
// Optional: define NIBBLE_PARITY_EN to add the OutParity output.
// Ports:
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   Flush             synchronous clear of FIFO and sequencer
//   InValid/InReady   byte input handshake, InByte carries the byte
//   OutValid/OutReady nibble output handshake, OutNibble carries the nibble
//   OutLast           high on the second nibble of a byte
//   Level             bytes waiting in the FIFO (excludes the byte being emitted)
//   OutParity         (NIBBLE_PARITY_EN only) XOR of OutNibble bits
module nibble_stream_sequencer #(
   parameter int DEPTH      = 4,
   parameter int HIGH_FIRST = 0
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       Flush,
   input  logic                       InValid,
   output logic                       InReady,
   input  logic [7:0]                 InByte,
   output logic                       OutValid,
   input  logic                       OutReady,
   output logic [3:0]                 OutNibble,
   output logic                       OutLast,
   output logic [$clog2(DEPTH+1)-1:0] Level
`ifdef NIBBLE_PARITY_EN
   ,
   output logic                       OutParity
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int LW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FIRST,
      S_SECOND
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [7:0]    hold_q, hold_d;
   logic [3:0]    nib_q, nib_d;
   logic          last_q, last_d;
   logic          valid_q, valid_d;
   logic          full, empty, push, pop;
   logic [7:0]    head;

   function automatic logic [3:0] first_half(input logic [7:0] b);
      return (HIGH_FIRST != 0) ? b[7:4] : b[3:0];
   endfunction

   function automatic logic [3:0] second_half(input logic [7:0] b);
      return (HIGH_FIRST != 0) ? b[3:0] : b[7:4];
   endfunction

   // Extra MSB on the pointers distinguishes full from empty.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   assign InReady = !full && !Flush && RST_N;
   assign push    = InValid && InReady;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      nib_d   = nib_q;
      last_d  = last_q;
      valid_d = valid_q;
      pop     = 1'b0;
      if (Flush) begin
         state_d = S_IDLE;
         hold_d  = '0;
         valid_d = 1'b0;
         last_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = S_FIRST;
                  hold_d  = head;
                  nib_d   = first_half(head);
                  last_d  = 1'b0;
                  valid_d = 1'b1;
               end
            end
            S_FIRST: begin
               if (OutReady) begin
                  state_d = S_SECOND;
                  nib_d   = second_half(hold_q);
                  last_d  = 1'b1;
               end
            end
            S_SECOND: begin
               if (OutReady) begin
                  // Chain straight into the next byte so the link never bubbles.
                  if (!empty) begin
                     pop     = 1'b1;
                     state_d = S_FIRST;
                     hold_d  = head;
                     nib_d   = first_half(head);
                     last_d  = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                     valid_d = 1'b0;
                     last_d  = 1'b0;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               last_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         hold_q   <= '0;
         nib_q    <= '0;
         last_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         nib_q   <= nib_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         if (Flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

   // Storage needs no reset; pointers define which entries are meaningful.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= InByte;
   end

   assign OutValid  = valid_q;
   assign OutNibble = nib_q;
   assign OutLast   = last_q;
   assign Level     = LW'(wr_ptr_q - rd_ptr_q);

`ifdef NIBBLE_PARITY_EN
   logic par_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) par_q <= 1'b0;
      else        par_q <= ^nib_d;
   end

   assign OutParity = par_q;
`endif

endmodule

// File: tb/tb_nibble_stream_sequencer.sv
// tb/tb_nibble_stream_sequencer.sv - scoreboard bench for nibble_stream_sequencer
module tb_nibble_stream_sequencer;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH + 1);

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          Flush = 1'b0;
   logic          InValid = 1'b0;
   logic [7:0]    InByte = '0;
   logic          OutReady = 1'b0;
   logic          InReady, OutValid, OutLast;
   logic [3:0]    OutNibble;
   logic [LW-1:0] Level;

   logic          h_Flush = 1'b0;
   logic          h_InValid = 1'b0;
   logic [7:0]    h_InByte = '0;
   logic          h_OutReady = 1'b1;
   logic          h_InReady, h_OutValid, h_OutLast;
   logic [3:0]    h_OutNibble;
   logic [LW-1:0] h_Level;

`ifdef NIBBLE_PARITY_EN
   logic          OutParity, h_OutParity;
`endif

   int n_vec = 0;
   int n_miscmp = 0;
   logic [4:0] sb_q[$];
   logic [4:0] hsb_q[$];

   nibble_stream_sequencer #(.DEPTH(DEPTH), .HIGH_FIRST(0)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .Flush(Flush),
      .InValid(InValid), .InReady(InReady), .InByte(InByte),
      .OutValid(OutValid), .OutReady(OutReady), .OutNibble(OutNibble),
      .OutLast(OutLast), .Level(Level)
`ifdef NIBBLE_PARITY_EN
      , .OutParity(OutParity)
`endif
   );

   nibble_stream_sequencer #(.DEPTH(DEPTH), .HIGH_FIRST(1)) u_dut_hf (
      .CLK(CLK), .RST_N(RST_N), .Flush(h_Flush),
      .InValid(h_InValid), .InReady(h_InReady), .InByte(h_InByte),
      .OutValid(h_OutValid), .OutReady(h_OutReady), .OutNibble(h_OutNibble),
      .OutLast(h_OutLast), .Level(h_Level)
`ifdef NIBBLE_PARITY_EN
      , .OutParity(h_OutParity)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected beat {last, nibble} for one half of a byte.
   function automatic logic [4:0] beat(input logic [7:0] b, input bit hf, input bit second);
      logic [3:0] n;
      n = (hf ^ second) ? b[7:4] : b[3:0];
      return {second, n};
   endfunction

   always @(negedge CLK) begin
      logic [4:0] e;
      if (RST_N && OutValid && OutReady && !Flush) begin
         if (sb_q.size() == 0) check("sb_unexpected_beat", 1, 0);
         else begin
            e = sb_q.pop_front();
            check("sb_nibble", OutNibble, e[3:0]);
            check("sb_last", OutLast, e[4]);
`ifdef NIBBLE_PARITY_EN
            check("sb_parity", OutParity, ^e[3:0]);
`endif
         end
      end
   end

   always @(negedge CLK) begin
      logic [4:0] e;
      if (RST_N && h_OutValid && h_OutReady) begin
         if (hsb_q.size() == 0) check("hf_unexpected_beat", 1, 0);
         else begin
            e = hsb_q.pop_front();
            check("hf_nibble", h_OutNibble, e[3:0]);
            check("hf_last", h_OutLast, e[4]);
`ifdef NIBBLE_PARITY_EN
            check("hf_parity", h_OutParity, ^e[3:0]);
`endif
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      InValid = 1'b1;
      InByte  = b;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (InReady) begin
            sb_q.push_back(beat(b, 1'b0, 1'b0));
            sb_q.push_back(beat(b, 1'b0, 1'b1));
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("push_timeout", 0, 1);
      @(posedge CLK);
      #1;
      InValid = 1'b0;
   endtask

   task automatic wait_valid();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         if (OutValid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("valid_timeout", 0, 1);
      @(posedge CLK);
      #1;
   endtask

   task automatic drain(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (sb_q.size() == 0 && !OutValid) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, ok, 1);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [3:0] stall_nib [6];
      logic       stall_rdy [6];

      // Reset state
      #3;
      check("rst_valid", OutValid, 0);
      check("rst_nibble", OutNibble, 0);
      check("rst_last", OutLast, 0);
      check("rst_level", Level, 0);
      check("rst_inready", InReady, 0);
`ifdef NIBBLE_PARITY_EN
      check("rst_parity", OutParity, 0);
`endif
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      @(negedge CLK);
      check("post_rst_inready", InReady, 1);
      @(posedge CLK);
      #1;

      // 1: single byte, latency
      OutReady = 1'b1;
      send_byte(8'hA5);
      @(negedge CLK);
      check("lat_edge_n1", OutValid, 0);
      @(negedge CLK);
      check("lat_edge_n2", OutValid, 1);
      drain("drain_a5");

      // 2: HIGH_FIRST=1, back-to-back bytes, no bubble
      h_InValid = 1'b1;
      h_InByte  = 8'h3C;
      @(negedge CLK);
      check("hf_inready0", h_InReady, 1);
      hsb_q.push_back(beat(8'h3C, 1'b1, 1'b0));
      hsb_q.push_back(beat(8'h3C, 1'b1, 1'b1));
      @(posedge CLK);
      #1;
      h_InByte = 8'h81;
      @(negedge CLK);
      check("hf_inready1", h_InReady, 1);
      hsb_q.push_back(beat(8'h81, 1'b1, 1'b0));
      hsb_q.push_back(beat(8'h81, 1'b1, 1'b1));
      @(posedge CLK);
      #1;
      h_InValid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         check("hf_no_bubble", h_OutValid, 1);
      end
      @(negedge CLK);
      check("hf_idle_after", h_OutValid, 0);
      check("hf_sb_empty", hsb_q.size(), 0);
      @(posedge CLK);
      #1;

      // 3: fill under backpressure
      OutReady = 1'b0;
      for (int b = 8'h10; b <= 8'h14; b++) send_byte(8'(b));
      InValid = 1'b1;
      InByte  = 8'h15;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check("full_inready", InReady, 0);
         check("full_level", Level, 4);
         check("full_hold_nibble", OutNibble, 4'h0);
         check("full_hold_valid", OutValid, 1);
         @(posedge CLK);
         #1;
      end
      OutReady = 1'b1;
      send_byte(8'h15);
      drain("drain_fill");

      // 4: stalls hold the presented nibble
      OutReady = 1'b0;
      send_byte(8'h7E);
      wait_valid();
      stall_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      stall_nib = '{4'hE, 4'hE, 4'hE, 4'h7, 4'h7, 4'h7};
      for (int k = 0; k < 6; k++) begin
         OutReady = stall_rdy[k];
         @(negedge CLK);
         check("stall_valid", OutValid, 1);
         check("stall_nibble", OutNibble, stall_nib[k]);
         @(posedge CLK);
         #1;
      end
      OutReady = 1'b0;
      drain("drain_stall");

      // 5: flush mid-byte with bytes queued
      send_byte(8'hB2);
      wait_valid();
      send_byte(8'hC1);
      send_byte(8'hD3);
      OutReady = 1'b1;
      @(negedge CLK);
      check("flush_pre_level", Level, 2);
      @(posedge CLK);
      #1;
      OutReady = 1'b0;
      Flush    = 1'b1;
      InValid  = 1'b1;
      InByte   = 8'hEE;
      sb_q.delete();
      @(negedge CLK);
      check("flush_inready", InReady, 0);
      @(posedge CLK);
      #1;
      Flush   = 1'b0;
      InValid = 1'b0;
      @(negedge CLK);
      check("flush_valid", OutValid, 0);
      check("flush_last", OutLast, 0);
      check("flush_level", Level, 0);
      @(posedge CLK);
      #1;
      OutReady = 1'b1;
      send_byte(8'h44);
      drain("drain_after_flush");

      // 6: parity stream, then async reset mid-stream
      send_byte(8'h0F);
      send_byte(8'h17);
      drain("drain_parity");
      OutReady = 1'b0;
      send_byte(8'h5A);
      send_byte(8'h6B);
      wait_valid();
      #2;
      RST_N = 1'b0;
      sb_q.delete();
      #1;
      check("arst_valid", OutValid, 0);
      check("arst_nibble", OutNibble, 0);
      check("arst_last", OutLast, 0);
      check("arst_level", Level, 0);
      check("arst_inready", InReady, 0);
`ifdef NIBBLE_PARITY_EN
      check("arst_parity", OutParity, 0);
`endif
      @(negedge CLK);
      check("arst_inready_held", InReady, 0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      @(negedge CLK);
      check("arst_release_inready", InReady, 1);
      check("arst_release_valid", OutValid, 0);
      @(posedge CLK);
      #1;
      OutReady = 1'b1;
      send_byte(8'h96);
      drain("drain_after_arst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
